floating_point_alu: RTL and testbench

Single-precision (IEEE-754 binary32) arithmetic unit: adds or multiplies two operands selected by `sel`. Results are truncated and registered, and a flag reports significand carry (add) or exponent overflow (multiply). It sits as a leaf datapath block behind a register-file/operand mux; there is no handshake, and a new operation is accepted every cycle.

---
 rtl/fp_alu_pkg.sv | 39 +++
 rtl/fp_lzc_normalize.sv | 23 ++
 rtl/floating_point_alu.sv | 212 +++++++++++++++++++++
 tb/tb_floating_point_alu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared types and constants for the binary32 add/multiply unit.
// FP_ALU_ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
package fp_alu_pkg;

  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int BIAS    = 127;
  localparam int EXP_MAX = 255;
  localparam int SIG_W   = FRAC_W + 1;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

`ifdef FP_ALU_ROUND_NEAREST_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp32_t;

  // Round a 24-bit significand using guard/round/sticky; bit 24 of the
  // result flags a rounding carry. With truncation the increment is zero.
  function automatic logic [SIG_W:0] round_sig(
    input logic [SIG_W-1:0] sig,
    input logic             g,
    input logic             r,
    input logic             s
  );
    logic inc;
    inc = RNE_EN & g & (r | s | sig[0]);
    return {1'b0, sig} + {{SIG_W{1'b0}}, inc};
  endfunction

endpackage

// File: rtl/fp_lzc_normalize.sv
// Leading-zero count and left-normalize for the add path.
module fp_lzc_normalize #(
  parameter int W  = 25,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  val_i,
  output logic [W-1:0]  norm_o,
  output logic [CW-1:0] lzc_o,
  output logic          zero_o
);

  // Scan upward so the highest set bit determines the count; all-zero gives W.
  always_comb begin
    lzc_o = CW'(W);
    for (int i = 0; i < W; i++) begin
      lzc_o = val_i[i] ? CW'(W - 1 - i) : lzc_o;
    end
  end

  assign norm_o = val_i << lzc_o;
  assign zero_o = (val_i == '0);

endmodule

// File: rtl/floating_point_alu.sv
// Binary32 add/multiply with one-cycle registered result.
// Exp==0 operands are flushed to zero; exp==255 is handled as a finite value.
// FP_ALU_ROUND_NEAREST_EN (in fp_alu_pkg) switches truncation to round-nearest-even.
module floating_point_alu
  import fp_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] result,
  output logic        overflow,
  output logic        done
);

  fp32_t op_a_s, op_b_s;
  logic  a_zero_s, b_zero_s;

  assign op_a_s   = a;
  assign op_b_s   = b;
  assign a_zero_s = (op_a_s.exp == 8'd0);
  assign b_zero_s = (op_b_s.exp == 8'd0);

  // ---------------- add path ----------------
  fp32_t       big_s, small_s;
  logic [7:0]  exp_diff_s;
  logic [23:0] sig_big_s, sig_small_s, small_trunc_s;
  logic [26:0] small_full_s, small_shift_s, lost_mask_s, small_ext_s;
  logic        sticky_s, add_same_s, add_carry_s;
  logic [27:0] add_sum_s;
  logic [26:0] norm_sig_s;
  logic [4:0]  norm_lzc_s;
  logic        norm_zero_s;

  // Order operands by magnitude, align the smaller one and add or subtract.
  always_comb begin
    if (a[30:0] >= b[30:0]) begin
      big_s   = op_a_s;
      small_s = op_b_s;
    end else begin
      big_s   = op_b_s;
      small_s = op_a_s;
    end
    exp_diff_s   = big_s.exp - small_s.exp;
    sig_big_s    = {1'b1, big_s.frac};
    sig_small_s  = {1'b1, small_s.frac};
    small_full_s = {sig_small_s, 3'b000};
    if (exp_diff_s >= 8'd24) begin
      small_trunc_s = 24'd0;
    end else begin
      small_trunc_s = sig_small_s >> exp_diff_s;
    end
    if (exp_diff_s >= 8'd27) begin
      small_shift_s = 27'd0;
      lost_mask_s   = {27{1'b1}};
    end else begin
      small_shift_s = small_full_s >> exp_diff_s;
      lost_mask_s   = ~({27{1'b1}} << exp_diff_s);
    end
    sticky_s = |(small_full_s & lost_mask_s);
    // Truncation discards shifted-out bits before the subtraction.
    if (RNE_EN) begin
      small_ext_s = {small_shift_s[26:1], small_shift_s[0] | sticky_s};
    end else begin
      small_ext_s = {small_trunc_s, 3'b000};
    end
    add_same_s = (big_s.sign == small_s.sign);
    if (add_same_s) begin
      add_sum_s = {1'b0, sig_big_s, 3'b000} + {1'b0, small_ext_s};
    end else begin
      add_sum_s = {1'b0, sig_big_s, 3'b000} - {1'b0, small_ext_s};
    end
    add_carry_s = add_same_s & add_sum_s[27];
  end

  fp_lzc_normalize #(.W(27), .CW(5)) u_norm (
    .val_i  (add_sum_s[26:0]),
    .norm_o (norm_sig_s),
    .lzc_o  (norm_lzc_s),
    .zero_o (norm_zero_s)
  );

  logic [26:0] add_sig_s;
  logic [9:0]  add_exp_s;
  logic [24:0] add_rnd_s;
  logic [22:0] add_frac_s;
  logic [31:0] add_res_s;
  logic        add_ovf_s;

  // Normalize, round and range-check the add result, with zero-operand bypass.
  always_comb begin
    if (add_carry_s) begin
      add_sig_s = {add_sum_s[27:2], add_sum_s[1] | add_sum_s[0]};
      add_exp_s = {2'b00, big_s.exp} + 10'd1;
    end else begin
      add_sig_s = norm_sig_s;
      add_exp_s = {2'b00, big_s.exp} - {5'd0, norm_lzc_s};
    end
    add_rnd_s = round_sig(add_sig_s[26:3], add_sig_s[2], add_sig_s[1], add_sig_s[0]);
    if (add_rnd_s[24]) begin
      add_exp_s  = add_exp_s + 10'd1;
      add_frac_s = add_rnd_s[23:1];
    end else begin
      add_frac_s = add_rnd_s[22:0];
    end
    if (a_zero_s && b_zero_s) begin
      add_res_s = 32'h0000_0000;
      add_ovf_s = 1'b0;
    end else if (a_zero_s) begin
      add_res_s = b;
      add_ovf_s = 1'b0;
    end else if (b_zero_s) begin
      add_res_s = a;
      add_ovf_s = 1'b0;
    end else if (!add_carry_s && norm_zero_s) begin
      add_res_s = 32'h0000_0000;
      add_ovf_s = 1'b0;
    end else if (add_exp_s[9] || (add_exp_s == 10'd0)) begin
      add_res_s = 32'h0000_0000;
      add_ovf_s = 1'b0;
    end else if ((add_exp_s >= 10'(EXP_MAX)) && (add_exp_s > {2'b00, big_s.exp})) begin
      // Only an exponent bump (carry or rounding) can push into Inf.
      add_res_s = {big_s.sign, 8'hFF, 23'd0};
      add_ovf_s = add_carry_s;
    end else begin
      add_res_s = {big_s.sign, add_exp_s[7:0], add_frac_s};
      add_ovf_s = add_carry_s;
    end
  end

  // ---------------- multiply path ----------------
  logic [47:0] mul_prod_s;
  logic [23:0] mul_sig_s;
  logic        mul_g_s, mul_r_s, mul_st_s;
  logic [9:0]  mul_exp_s;
  logic [24:0] mul_rnd_s;
  logic [22:0] mul_frac_s;
  logic [31:0] mul_res_s;
  logic        mul_ovf_s;

  // Significand product, one-step normalize, round and range-check.
  always_comb begin
    mul_prod_s = {24'd0, 1'b1, op_a_s.frac} * {24'd0, 1'b1, op_b_s.frac};
    mul_exp_s  = {2'b00, op_a_s.exp} + {2'b00, op_b_s.exp} - 10'(BIAS)
               + {9'd0, mul_prod_s[47]};
    if (mul_prod_s[47]) begin
      mul_sig_s = mul_prod_s[47:24];
      mul_g_s   = mul_prod_s[23];
      mul_r_s   = mul_prod_s[22];
      mul_st_s  = |mul_prod_s[21:0];
    end else begin
      mul_sig_s = mul_prod_s[46:23];
      mul_g_s   = mul_prod_s[22];
      mul_r_s   = mul_prod_s[21];
      mul_st_s  = |mul_prod_s[20:0];
    end
    mul_rnd_s = round_sig(mul_sig_s, mul_g_s, mul_r_s, mul_st_s);
    if (mul_rnd_s[24]) begin
      mul_exp_s  = mul_exp_s + 10'd1;
      mul_frac_s = mul_rnd_s[23:1];
    end else begin
      mul_frac_s = mul_rnd_s[22:0];
    end
    if (a_zero_s || b_zero_s) begin
      mul_res_s = 32'h0000_0000;
      mul_ovf_s = 1'b0;
    end else if (mul_exp_s[9] || (mul_exp_s == 10'd0)) begin
      mul_res_s = 32'h0000_0000;
      mul_ovf_s = 1'b0;
    end else if (mul_exp_s >= 10'(EXP_MAX)) begin
      mul_res_s = {op_a_s.sign ^ op_b_s.sign, 8'hFF, 23'd0};
      mul_ovf_s = 1'b1;
    end else begin
      mul_res_s = {op_a_s.sign ^ op_b_s.sign, mul_exp_s[7:0], mul_frac_s};
      mul_ovf_s = 1'b0;
    end
  end

  // ---------------- output register ----------------
  logic [31:0] result_d, result_q;
  logic        overflow_d, overflow_q, done_q;

  // Select the requested operation's result.
  always_comb begin
    if (sel == OP_MUL) begin
      result_d   = mul_res_s;
      overflow_d = mul_ovf_s;
    end else begin
      result_d   = add_res_s;
      overflow_d = add_ovf_s;
    end
  end

  // Capture every cycle; reset clears outputs immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q   <= 32'h0000_0000;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      done_q     <= 1'b1;
    end
  end

  assign result   = result_q;
  assign overflow = overflow_q;
  assign done     = done_q;

endmodule

// File: tb/tb_floating_point_alu.sv
// Randomized bench for floating_point_alu with an integer-arithmetic reference model.
module tb_floating_point_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] a = 32'h0;
  logic [31:0] b = 32'h0;
  logic        sel = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        done;

  floating_point_alu dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sel      (sel),
    .result   (result),
    .overflow (overflow),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;
  logic probe  = 1'b0;

  // literal expectation attached to the op currently on the inputs
  logic        lit_v = 1'b0;
  logic [31:0] lit_r = 32'h0;
  logic        lit_o = 1'b0;

  // model state for what the outputs must show now
  logic [31:0] m_res = 32'h0;
  logic        m_ovf = 1'b0;
  logic        m_done = 1'b0;
  logic        m_lit_v = 1'b0;
  logic [31:0] m_lit_r = 32'h0;
  logic        m_lit_o = 1'b0;

  localparam int ND = 15;
  localparam logic [31:0] VA [ND] = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000,
    32'hBF000000, 32'h41200000, 32'h41200000, 32'h4121999A, 32'h4121999A, 32'h7F000000,
    32'h3F800000, 32'h7F000000, 32'h4C000000, 32'h00800000, 32'h3F800000};
  localparam logic [31:0] VB [ND] = '{32'h00000000, 32'h00000000, 32'hBF800000, 32'hBF800000,
    32'hC0CCCCCC, 32'h41700000, 32'h41700000, 32'h4129999A, 32'hC1200000, 32'h7F000000,
    32'hBF800000, 32'h7F000000, 32'h3F800000, 32'h00800000, 32'hBF400000};
  localparam logic VS [ND] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam logic [31:0] VR [ND] = '{32'h00000000, 32'h00000000, 32'hBF800000, 32'h00000000,
    32'hC0DCCCCC, 32'h41C80000, 32'h43160000, 32'h41A5999A, 32'hC2CA0000, 32'h7F800000,
    32'h00000000, 32'h7F800000, 32'h4C000000, 32'h00000000, 32'h3E800000};
  localparam logic VO [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

  function automatic int msb_pos(input longint unsigned v);
    int p;
    p = -1;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) p = i;
    end
    return p;
  endfunction

  function automatic logic [22:0] frac_of(input longint unsigned m, input int p);
    longint unsigned t;
    if (p >= 23) t = m >> (p - 23);
    else t = m << (23 - p);
    return t[22:0];
  endfunction

  // Value = M * 2^(E-150) with M the 24-bit significand; returns {ovf, result}.
  function automatic logic [32:0] fp_model(input logic [31:0] x, input logic [31:0] y,
                                           input logic op);
    int ex, ey, eb, es, diff, p, e;
    longint unsigned mx, my, mb, ms, mag;
    logic sx, sy, sg;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    sx = x[31];
    sy = y[31];
    mx = {40'd0, 1'b1, x[22:0]};
    my = {40'd0, 1'b1, y[22:0]};
    if (op == 1'b0) begin
      if (ex == 0 && ey == 0) return 33'h0;
      if (ex == 0) return {1'b0, y};
      if (ey == 0) return {1'b0, x};
      if (x[30:0] >= y[30:0]) begin
        eb = ex; es = ey; mb = mx; ms = my; sg = sx;
      end else begin
        eb = ey; es = ex; mb = my; ms = mx; sg = sy;
      end
      diff = eb - es;
      if (diff >= 24) ms = 0;
      else ms = ms >> diff;
      mag = (sx == sy) ? mb + ms : mb - ms;
      if (mag == 0) return 33'h0;
      p = msb_pos(mag);
      e = eb + p - 23;
      if (e <= 0) return 33'h0;
      if (p == 24 && e >= 255) return {1'b1, sg, 8'hFF, 23'h0};
      return {p == 24, sg, 8'(e), frac_of(mag, p)};
    end else begin
      if (ex == 0 || ey == 0) return 33'h0;
      mag = mx * my;
      p = msb_pos(mag);
      e = ex + ey - 127 + (p - 46);
      if (e >= 255) return {1'b1, sx ^ sy, 8'hFF, 23'h0};
      if (e <= 0) return 33'h0;
      return {1'b0, sx ^ sy, 8'(e), frac_of(mag, p)};
    end
  endfunction

  // Model what the registered outputs hold after each edge or reset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_res   <= 32'h0;
      m_ovf   <= 1'b0;
      m_done  <= 1'b0;
      m_lit_v <= 1'b0;
    end else begin
      {m_ovf, m_res} <= fp_model(a, b, sel);
      m_done  <= 1'b1;
      m_lit_v <= lit_v;
      m_lit_r <= lit_r;
      m_lit_o <= lit_o;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h (a=%08h b=%08h sel=%0b t=%0t)",
               name, act, exp, a, b, sel, $time);
    end
  endtask

  // Single compare process: every negedge against the model, plus async reset probes.
  always begin
    @(negedge clk or posedge probe);
    if (chk_en) begin
      if (probe) begin
        check("async_rst_result", result, 32'h0);
        check("async_rst_overflow", {31'd0, overflow}, 32'h0);
        check("async_rst_done", {31'd0, done}, 32'h0);
      end else begin
        check("result", result, m_res);
        check("overflow", {31'd0, overflow}, {31'd0, m_ovf});
        check("done", {31'd0, done}, {31'd0, m_done});
        if (m_lit_v) begin
          check("model_vs_literal_result", m_res, m_lit_r);
          check("model_vs_literal_overflow", {31'd0, m_ovf}, {31'd0, m_lit_o});
          check("literal_result", result, m_lit_r);
          check("literal_overflow", {31'd0, overflow}, {31'd0, m_lit_o});
          check("literal_done", {31'd0, done}, 32'h1);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic s,
                       input logic lv, input logic [31:0] lr, input logic lo);
    a = x; b = y; sel = s;
    lit_v = lv; lit_r = lr; lit_o = lo;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pick_exp();
    int unsigned k;
    k = $urandom_range(0, 9);
    case (k)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'($urandom_range(1, 10));
      3: return 8'($urandom_range(245, 254));
      default: return 8'($urandom_range(100, 160));
    endcase
  endfunction

  function automatic logic [22:0] rand_frac();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) == 0) return 23'h7FFFFF;
    return r[22:0];
  endfunction

  initial begin
    logic [7:0]  ea, eb;
    logic [31:0] ra, rb;
    int t;
    #3 rst = 1'b1;
    #1 chk_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 9; i++) drive(VA[i], VB[i], VS[i], 1'b1, VR[i], VO[i]);

    for (int i = 0; i < 20; i++)
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);

    // Reset mid-stream: the pending op is dropped, outputs clear without an edge.
    a = 32'h41200000; b = 32'h41700000; sel = 1'b0; lit_v = 1'b0;
    #1 rst = 1'b1;
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 9; i < ND; i++) drive(VA[i], VB[i], VS[i], 1'b1, VR[i], VO[i]);

    for (int n = 0; n < 1500; n++) begin
      ea = pick_exp();
      if ($urandom_range(0, 1) == 0) begin
        eb = pick_exp();
      end else begin
        t = int'(ea) + int'($urandom_range(0, 60)) - 30;
        if (t < 0) t = 0;
        if (t > 255) t = 255;
        eb = 8'(t);
      end
      ra = {1'($urandom_range(0, 1)), ea, rand_frac()};
      rb = {1'($urandom_range(0, 1)), eb, rand_frac()};
      if ($urandom_range(0, 15) == 0) rb = {~ra[31], ra[30:0]};
      drive(ra, rb, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
